// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan controller.
//   - glyph code constants for the non-hex symbols
//   - seg7_glyph(): 5-bit glyph code -> active-low cathode pattern {g..a}
//   - seg7_thr_width(): width needed to hold a brightness threshold (0..L)
package seg7_pkg;

    localparam logic [4:0] SEG7_BLANK = 5'h10;
    localparam logic [4:0] SEG7_DASH  = 5'h11;
    localparam logic [4:0] SEG7_L     = 5'h12;
    localparam logic [4:0] SEG7_R     = 5'h13;
    localparam logic [4:0] SEG7_O     = 5'h14;
    localparam logic [4:0] SEG7_B     = 5'h15;
    localparam logic [4:0] SEG7_U     = 5'h16;
    localparam logic [4:0] SEG7_P     = 5'h17;

    localparam logic [6:0] SEG7_OFF   = 7'h7F;

    // Active-low cathode pattern, bit 0 = segment a, bit 6 = segment g.
    function automatic logic [6:0] seg7_glyph(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'h00:     pat = 7'h40;
            5'h01:     pat = 7'h79;
            5'h02:     pat = 7'h24;
            5'h03:     pat = 7'h30;
            5'h04:     pat = 7'h19;
            5'h05:     pat = 7'h12;
            5'h06:     pat = 7'h02;
            5'h07:     pat = 7'h78;
            5'h08:     pat = 7'h00;
            5'h09:     pat = 7'h10;
            5'h0A:     pat = 7'h08;
            5'h0B:     pat = 7'h03;
            5'h0C:     pat = 7'h46;
            5'h0D:     pat = 7'h21;
            5'h0E:     pat = 7'h06;
            5'h0F:     pat = 7'h0E;
            SEG7_DASH: pat = 7'h3F;
            SEG7_L:    pat = 7'h47;
            SEG7_R:    pat = 7'h2F;
            SEG7_O:    pat = 7'h23;
            SEG7_B:    pat = 7'h03;
            SEG7_U:    pat = 7'h41;
            SEG7_P:    pat = 7'h0C;
            default:   pat = SEG7_OFF;
        endcase
        return pat;
    endfunction

    // Threshold ranges over 0..slot_len inclusive (full brightness equals slot_len).
    function automatic int unsigned seg7_thr_width(input int unsigned slot_len);
        return $clog2(slot_len + 1);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: registered glyph decoder.
//   clk, reset : clock, synchronous active-high reset
//   code       : 5-bit glyph code
//   dp_in      : decimal point request, 1 = lit
//   en         : 0 forces all cathodes off
//   seg, dp    : registered active-low cathodes
module seg7_decode
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] code,
    input  logic       dp_in,
    input  logic       en,
    output logic [6:0] seg,
    output logic       dp
);

    logic [6:0] seg_q;
    logic       dp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= SEG7_OFF;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= en ? seg7_glyph(code) : SEG7_OFF;
            dp_q  <= en ? ~dp_in : 1'b1;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed seven-segment display controller.
//   clk, reset  : clock, synchronous active-high reset
//   digits_in   : 5-bit glyph code per digit, digit i at [5i+4:5i]
//   dp_in       : decimal point per digit, 1 = lit
//   blank_in    : 1 = digit dark
//   brightness  : 0 = dimmest, 15 = full
//   load        : strobe capturing the data inputs into the pending bank
//   blink_in    : (SEG7_BLINK_EN only) digit blinks with the frame-counter phase
//   seg, dp, an : registered active-low cathodes and anodes
//   frame_done  : pulse aligned with the output cycle of the last slot of a frame
// Optional feature: define SEG7_BLINK_EN to add blink_in and the blink frame counter.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 9375,
    parameter int unsigned SIMULATE   = 0,
    parameter int unsigned DEAD_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [3:0]              brightness,
    input  logic                    load,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned SLOT_LEN = (SIMULATE != 0) ? 8 : SCAN_DIV;
    localparam int unsigned SLOT_W   = $clog2(SLOT_LEN);
    localparam int unsigned DIG_W    = $clog2(NUM_DIGITS);
    localparam int unsigned THR_W    = seg7_thr_width(SLOT_LEN);
    localparam int unsigned DW       = 5 * NUM_DIGITS;

    function automatic logic [THR_W-1:0] calc_thr(input logic [3:0] level);
        int unsigned scaled;
        scaled = ((32'(level) + 32'd1) * SLOT_LEN) >> 4;
        return THR_W'(scaled);
    endfunction

    logic [SLOT_W-1:0]     slot_cnt_q;
    logic [DIG_W-1:0]      dig_idx_q;
    logic [DW-1:0]         pend_digits_q, pend_digits_d, act_digits_q, eff_digits;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, eff_dp;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, act_blank_q, eff_blank;
    logic [3:0]            pend_bright_q, pend_bright_d;
    logic [THR_W-1:0]      thr_q, thr_eff;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q;
    logic                  slot_last, dig_last, frame_start, cur_blank, an_en, cur_dp;
    logic [4:0]            cur_code;

`ifdef SEG7_BLINK_EN
    logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d, act_blink_q, eff_blink;
    logic [8:0]            frame_cnt_q;
    logic                  blink_phase;
`endif

    always_comb begin
        slot_last   = (slot_cnt_q == SLOT_W'(SLOT_LEN - 1));
        dig_last    = (dig_idx_q == DIG_W'(NUM_DIGITS - 1));
        frame_start = (slot_cnt_q == '0) && (dig_idx_q == '0);

        pend_digits_d = load ? digits_in  : pend_digits_q;
        pend_dp_d     = load ? dp_in      : pend_dp_q;
        pend_blank_d  = load ? blank_in   : pend_blank_q;
        pend_bright_d = load ? brightness : pend_bright_q;

        // The frame-start cycle already displays the bank being promoted, so a
        // load coinciding with frame_done lands in the frame that starts now.
        eff_digits = frame_start ? pend_digits_d : act_digits_q;
        eff_dp     = frame_start ? pend_dp_d     : act_dp_q;
        eff_blank  = frame_start ? pend_blank_d  : act_blank_q;
        thr_eff    = frame_start ? calc_thr(pend_bright_d) : thr_q;

        cur_blank = eff_blank[dig_idx_q];
`ifdef SEG7_BLINK_EN
        pend_blink_d = load ? blink_in : pend_blink_q;
        eff_blink    = frame_start ? pend_blink_d : act_blink_q;
        blink_phase  = (SIMULATE != 0) ? frame_cnt_q[2] : frame_cnt_q[8];
        cur_blank    = cur_blank | (eff_blink[dig_idx_q] & blink_phase);
`endif

        // Dead cycles at slot start hide ghosting from the previous digit.
        an_en = !cur_blank
             && (32'(slot_cnt_q) >= DEAD_CYC)
             && (32'(slot_cnt_q) < 32'(thr_eff));

        cur_code = eff_digits[32'(dig_idx_q) * 5 +: 5];
        cur_dp   = eff_dp[dig_idx_q];

        an_d = '1;
        if (an_en) begin
            an_d[dig_idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q    <= '0;
            dig_idx_q     <= '0;
            frame_done_q  <= 1'b0;
            an_q          <= '1;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            pend_bright_q <= 4'hF;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            thr_q         <= calc_thr(4'hF);
`ifdef SEG7_BLINK_EN
            pend_blink_q  <= '0;
            act_blink_q   <= '0;
            frame_cnt_q   <= '0;
`endif
        end else begin
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_bright_q <= pend_bright_d;
            if (frame_start) begin
                act_digits_q <= eff_digits;
                act_dp_q     <= eff_dp;
                act_blank_q  <= eff_blank;
                thr_q        <= thr_eff;
            end
`ifdef SEG7_BLINK_EN
            pend_blink_q <= pend_blink_d;
            if (frame_start) begin
                act_blink_q <= eff_blink;
            end
            if (slot_last && dig_last) begin
                frame_cnt_q <= frame_cnt_q + 9'd1;
            end
`endif
            frame_done_q <= slot_last && dig_last;
            an_q         <= an_d;
            if (slot_last) begin
                slot_cnt_q <= '0;
                dig_idx_q  <= dig_last ? '0 : dig_idx_q + DIG_W'(1);
            end else begin
                slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
            end
        end
    end

    assign an         = an_q;
    assign frame_done = frame_done_q;

    seg7_decode u_decode (
        .clk   (clk),
        .reset (reset),
        .code  (cur_code),
        .dp_in (cur_dp),
        .en    (an_en),
        .seg   (seg),
        .dp    (dp)
    );

endmodule
